// File: rtl/btb_predictor_if.sv
// Fetch/resolve bus between the pipeline and the branch target buffer.
interface btb_predictor_if #(
  parameter int unsigned PC_W = 16
);
  logic [PC_W-1:0] pc_IF;
  logic            btb_hit_IF;
  logic [PC_W-1:0] btb_tgt_IF;
  logic            upd_en_EX;
  logic [PC_W-1:0] upd_pc_EX;
  logic [PC_W-1:0] upd_tgt_EX;
  logic            upd_taken_EX;
  logic            flush_btb;

  modport master (
    output pc_IF, upd_en_EX, upd_pc_EX, upd_tgt_EX, upd_taken_EX, flush_btb,
    input  btb_hit_IF, btb_tgt_IF
  );

  modport slave (
    input  pc_IF, upd_en_EX, upd_pc_EX, upd_tgt_EX, upd_taken_EX, flush_btb,
    output btb_hit_IF, btb_tgt_IF
  );
endinterface

// File: rtl/btb_predictor.sv
// Direct-mapped BTB with 2-bit saturating direction counters; combinational
// lookup in IF, sequential update from EX branch resolution.
module btb_predictor #(
  parameter int unsigned PC_W    = 16,
  parameter int unsigned ENTRIES = 8
) (
  input logic            clk,
  input logic            rst,
  btb_predictor_if.slave bus
);
  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam int unsigned TAG_W = PC_W - IDX_W;

  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q [ENTRIES];
  logic [PC_W-1:0]    tgt_q [ENTRIES];
  logic [1:0]         cnt_q [ENTRIES];

  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;
  logic [IDX_W-1:0] u_idx;
  logic [TAG_W-1:0] u_tag;
  logic             u_match;
  logic             lk_hit;

  always_comb begin
    lk_idx = bus.pc_IF[IDX_W-1:0];
    lk_tag = bus.pc_IF[PC_W-1:IDX_W];
    u_idx  = bus.upd_pc_EX[IDX_W-1:0];
    u_tag  = bus.upd_pc_EX[PC_W-1:IDX_W];
  end

  // Gate on valid first so uninitialised tag/target storage never leaks out.
  always_comb begin
    lk_hit  = 1'b0;
    u_match = 1'b0;
    if (valid_q[lk_idx])
      lk_hit = (tag_q[lk_idx] == lk_tag) && cnt_q[lk_idx][1];
    if (valid_q[u_idx])
      u_match = (tag_q[u_idx] == u_tag);
  end

  always_comb begin
    bus.btb_hit_IF = lk_hit;
    bus.btb_tgt_IF = lk_hit ? tgt_q[lk_idx] : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      cnt_q   <= '{default: 2'b00};
    end else if (bus.flush_btb) begin
      valid_q <= '0;
    end else if (bus.upd_en_EX) begin
      if (bus.upd_taken_EX) begin
        if (u_match) begin
          if (cnt_q[u_idx] != 2'b11)
            cnt_q[u_idx] <= cnt_q[u_idx] + 2'b01;
          tgt_q[u_idx] <= bus.upd_tgt_EX;
        end else begin
          valid_q[u_idx] <= 1'b1;
          tag_q[u_idx]   <= u_tag;
          tgt_q[u_idx]   <= bus.upd_tgt_EX;
          cnt_q[u_idx]   <= 2'b10;
        end
      end else if (u_match && cnt_q[u_idx] != 2'b00) begin
        cnt_q[u_idx] <= cnt_q[u_idx] - 2'b01;
      end
    end
  end
endmodule
